imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8: cycles a secondary request may wait before fetch is forcibly stalled; legal range 1..255.
REQ-002 Parameter MAX_BURST, default 4: maximum consecutive forced secondary grants before fetch is given a cycle; legal range 1..255.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 sys_reset  in  1  synchronous reset, same effect as reset_n.
REQ-006 stall_i  in  1  pipeline hazard stall; fetch must not advance.
REQ-007 fetch_addr_i  in  32  fetch instruction address (word aligned).
REQ-008 fetch_enable_o  out  1  drives fetch enable; 1 = fetch owns memory this cycle and advances.
REQ-009 sec_req_i  in  1  secondary requester (debug/load port) request, held until granted.
REQ-010 sec_addr_i, sec_wdata_i  in  32 each  secondary address / write data.
REQ-011 sec_we_i  in  1; sec_be_i  in  4  write enable, byte enables.
REQ-012 sec_gnt_o  out  1  request accepted this cycle; requester may change inputs next cycle.
REQ-013 sec_rvalid_o  out  1; sec_rdata_o  out  32  read response, one cycle after a read grant.
REQ-014 mem_addr_o  out  32; mem_we_o  out  4; mem_wdata_o  out  32  single-port synchronous memory; read data valid one cycle after address.
REQ-015 mem_rdata_i  in  32  memory read data.

Function
REQ-016 State machine states FETCH, SEC, YIELD; reset state FETCH.
REQ-017 starve_cnt (8 bit): increments (saturating) each cycle sec_req_i=1 and sec_gnt_o=0; clears on grant or when sec_req_i=0.
REQ-018 force = sec_req_i & (starve_cnt >= STARVE_LIMIT or state==SEC) & state!=YIELD.
REQ-019 sec_gnt_o = sec_req_i & (stall_i | force), combinational.
REQ-020 fetch_enable_o = !stall_i & !sec_gnt_o, combinational.
REQ-021 mem_addr_o = sec_addr_i when sec_gnt_o, else fetch_addr_i; mem_we_o = sec_be_i when sec_gnt_o & sec_we_i, else 4'b0; mem_wdata_o = sec_wdata_i.
REQ-022 burst_cnt (8 bit): increments on sec_gnt_o & !stall_i; clears on any cycle without sec_gnt_o; grants under stall_i=1 are free and never count.
REQ-023 Transitions: FETCH->SEC on forced grant with stall_i=0; SEC->YIELD when burst_cnt+1 reaches MAX_BURST on a grant; SEC->FETCH when no grant; YIELD->FETCH unconditionally after one cycle.
REQ-024 In YIELD, forced grants are blocked; grants under stall_i=1 remain allowed.
REQ-025 sec_rvalid_o registered: 1 the cycle after a grant with sec_we_i=0, else 0; sec_rdata_o = mem_rdata_i (combinational pass-through, valid only when sec_rvalid_o=1).
REQ-026 Writes produce no response.
REQ-027 Fetch never loses data: memory is lent only in cycles where fetch_enable_o=0, relying on the fetch unit holding its last word while disabled.
REQ-028 Worst-case secondary wait with stall_i=0 is STARVE_LIMIT cycles; fetch receives at least one enabled cycle in every MAX_BURST+1 cycles absent stall_i.
REQ-029 Simultaneous stall_i and sec_req_i: grant issued, starve_cnt and burst_cnt cleared.

Reset
REQ-030 reset_n low or sys_reset high: state FETCH, starve_cnt=0, burst_cnt=0, sec_rvalid_o=0; combinational outputs follow REQ-019..021 from cleared state.
REQ-031 Reset during a read grant suppresses the following sec_rvalid_o.

Verification
REQ-032 sec_req_i=1 read addr 0x100, stall_i=0, STARVE_LIMIT=8 -> sec_gnt_o=1 on 9th cycle, fetch_enable_o=0 that cycle, mem_addr_o=0x100, sec_rvalid_o=1 next cycle with mem_rdata_i.
REQ-033 stall_i=1 with sec_req_i=1 -> immediate grant, burst_cnt stays 0, fetch_enable_o=0.
REQ-034 sec_req_i held high continuously, stall_i=0, MAX_BURST=4 -> after starvation, 4 grants, 1 fetch cycle (YIELD), then grants resume immediately.
REQ-035 Write grant sec_be_i=4'b0011 -> mem_we_o=4'b0011 in grant cycle only, sec_rvalid_o stays 0.
REQ-036 reset_n asserted in read grant cycle -> sec_rvalid_o=0 next cycle, state FETCH, starve_cnt=0.
REQ-037 sec_req_i=0, stall_i toggling -> fetch_enable_o = !stall_i every cycle, mem_addr_o = fetch_addr_i.

Source files
------------

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - instruction memory arbiter between fetch and a secondary requester
module imem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int MAX_BURST    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sys_reset,
    input  logic        stall_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_enable_o,
    input  logic        sec_req_i,
    input  logic [31:0] sec_addr_i,
    input  logic [31:0] sec_wdata_i,
    input  logic        sec_we_i,
    input  logic [3:0]  sec_be_i,
    output logic        sec_gnt_o,
    output logic        sec_rvalid_o,
    output logic [31:0] sec_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {FETCH, SEC, YIELD} state_t;

    localparam logic [7:0] STARVE_LIM = STARVE_LIMIT[7:0];
    localparam logic [8:0] BURST_LIM  = MAX_BURST[8:0];

    state_t     state_q;
    logic [7:0] starve_cnt_q, starve_cnt_d;
    logic [7:0] burst_cnt_q, burst_cnt_d;
    logic       sec_rvalid_q;
    logic       forced_w;
    logic       gnt_w;
    logic       burst_last_w;

    always_comb begin
        forced_w     = sec_req_i & ((starve_cnt_q >= STARVE_LIM) | (state_q == SEC))
                       & (state_q != YIELD);
        gnt_w        = sec_req_i & (stall_i | forced_w);
        burst_last_w = ({1'b0, burst_cnt_q} + 9'd1) >= BURST_LIM;

        starve_cnt_d = starve_cnt_q;
        if (!sec_req_i || gnt_w) begin
            starve_cnt_d = 8'd0;
        end else if (state_q == YIELD) begin
            // A request held off by the yield slot is already starved, so the
            // burst resumes on the very next fetch cycle.
            starve_cnt_d = STARVE_LIM;
        end else if (starve_cnt_q != 8'hFF) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end

        burst_cnt_d = (gnt_w && !stall_i) ? burst_cnt_q + 8'd1 : 8'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FETCH;
            starve_cnt_q <= 8'd0;
            burst_cnt_q  <= 8'd0;
            sec_rvalid_q <= 1'b0;
        end else if (sys_reset) begin
            state_q      <= FETCH;
            starve_cnt_q <= 8'd0;
            burst_cnt_q  <= 8'd0;
            sec_rvalid_q <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            sec_rvalid_q <= gnt_w & ~sec_we_i;
            case (state_q)
                FETCH: begin
                    if (forced_w && !stall_i) begin
                        state_q <= burst_last_w ? YIELD : SEC;
                    end
                end
                SEC: begin
                    if (!gnt_w) begin
                        state_q <= FETCH;
                    end else if (!stall_i && burst_last_w) begin
                        state_q <= YIELD;
                    end
                end
                YIELD:   state_q <= FETCH;
                default: state_q <= FETCH;
            endcase
        end
    end

    assign sec_gnt_o      = gnt_w;
    assign fetch_enable_o = ~stall_i & ~gnt_w;
    assign mem_addr_o     = gnt_w ? sec_addr_i : fetch_addr_i;
    assign mem_we_o       = (gnt_w && sec_we_i) ? sec_be_i : 4'b0000;
    assign mem_wdata_o    = sec_wdata_i;
    assign sec_rvalid_o   = sec_rvalid_q;
    assign sec_rdata_o    = mem_rdata_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed self-checking bench for imem_arbiter
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sys_reset;
    logic        stall_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_enable_o;
    logic        sec_req_i;
    logic [31:0] sec_addr_i;
    logic [31:0] sec_wdata_i;
    logic        sec_we_i;
    logic [3:0]  sec_be_i;
    logic        sec_gnt_o;
    logic        sec_rvalid_o;
    logic [31:0] sec_rdata_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int vectors = 0;
    int miscompares = 0;

    imem_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(4)) dut (
        .clk(clk), .reset_n(reset_n), .sys_reset(sys_reset), .stall_i(stall_i),
        .fetch_addr_i(fetch_addr_i), .fetch_enable_o(fetch_enable_o),
        .sec_req_i(sec_req_i), .sec_addr_i(sec_addr_i), .sec_wdata_i(sec_wdata_i),
        .sec_we_i(sec_we_i), .sec_be_i(sec_be_i), .sec_gnt_o(sec_gnt_o),
        .sec_rvalid_o(sec_rvalid_o), .sec_rdata_o(sec_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Leaves time inside the cycle in which the grant appears.
    task automatic cycles_to_grant(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            if (n == 0) begin
                #1;
                if (sec_gnt_o) n = i;
                else cyc();
            end
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (fetch_enable_o !== 1'b1) begin miscompares++; $display("FAIL rst_fetch_en got %b exp 1", fetch_enable_o); end
        vectors++; if (sec_gnt_o !== 1'b0) begin miscompares++; $display("FAIL rst_gnt got %b exp 0", sec_gnt_o); end
        vectors++; if (sec_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid got %b exp 0", sec_rvalid_o); end
        vectors++; if (mem_addr_o !== 32'h40) begin miscompares++; $display("FAIL rst_mem_addr got %h exp 00000040", mem_addr_o); end
        vectors++; if (mem_we_o !== 4'b0) begin miscompares++; $display("FAIL rst_mem_we got %b exp 0000", mem_we_o); end
        sec_req_i = 1'b1;
        #1;
        vectors++; if (sec_gnt_o !== 1'b0) begin miscompares++; $display("FAIL rst_req_gnt got %b exp 0", sec_gnt_o); end
        cyc();
        vectors++; if (sec_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rst_hold_rvalid got %b exp 0", sec_rvalid_o); end
        reset_n = 1'b1;
        sec_req_i = 1'b0;
        cyc();
    endtask

    task automatic test_starve_read();
        sec_req_i = 1'b1; sec_addr_i = 32'h100; sec_we_i = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            #1;
            vectors++; if (sec_gnt_o !== 1'b0) begin miscompares++; $display("FAIL starve_wait_gnt cycle %0d got %b exp 0", i, sec_gnt_o); end
            vectors++; if (mem_addr_o !== fetch_addr_i) begin miscompares++; $display("FAIL starve_wait_addr cycle %0d got %h exp %h", i, mem_addr_o, fetch_addr_i); end
            cyc();
        end
        #1;
        vectors++; if (sec_gnt_o !== 1'b1) begin miscompares++; $display("FAIL starve_gnt got %b exp 1", sec_gnt_o); end
        vectors++; if (fetch_enable_o !== 1'b0) begin miscompares++; $display("FAIL starve_fetch_en got %b exp 0", fetch_enable_o); end
        vectors++; if (mem_addr_o !== 32'h100) begin miscompares++; $display("FAIL starve_mem_addr got %h exp 00000100", mem_addr_o); end
        vectors++; if (mem_we_o !== 4'b0) begin miscompares++; $display("FAIL starve_mem_we got %b exp 0000", mem_we_o); end
        cyc();
        sec_req_i = 1'b0; mem_rdata_i = 32'hDEADBEEF;
        #1;
        vectors++; if (sec_rvalid_o !== 1'b1) begin miscompares++; $display("FAIL starve_rvalid got %b exp 1", sec_rvalid_o); end
        vectors++; if (sec_rdata_o !== 32'hDEADBEEF) begin miscompares++; $display("FAIL starve_rdata got %h exp deadbeef", sec_rdata_o); end
        cyc();
        vectors++; if (sec_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL starve_rvalid_drop got %b exp 0", sec_rvalid_o); end
        cyc();
    endtask

    task automatic test_stall_grant();
        int n;
        sec_req_i = 1'b1; sec_addr_i = 32'h200; sec_we_i = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        stall_i = 1'b1;
        #1;
        vectors++; if (sec_gnt_o !== 1'b1) begin miscompares++; $display("FAIL stall_gnt got %b exp 1", sec_gnt_o); end
        vectors++; if (fetch_enable_o !== 1'b0) begin miscompares++; $display("FAIL stall_fetch_en got %b exp 0", fetch_enable_o); end
        vectors++; if (mem_addr_o !== 32'h200) begin miscompares++; $display("FAIL stall_mem_addr got %h exp 00000200", mem_addr_o); end
        mem_rdata_i = 32'h12345678;
        cyc();
        stall_i = 1'b0;
        #1;
        vectors++; if (sec_rvalid_o !== 1'b1) begin miscompares++; $display("FAIL stall_rvalid got %b exp 1", sec_rvalid_o); end
        vectors++; if (sec_rdata_o !== 32'h12345678) begin miscompares++; $display("FAIL stall_rdata got %h exp 12345678", sec_rdata_o); end
        cycles_to_grant(n);
        vectors++; if (n !== 9) begin miscompares++; $display("FAIL stall_clears_starve grant at cycle %0d exp 9", n); end
        sec_req_i = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_burst();
        logic exp_g;
        logic exp_prev;
        exp_prev = 1'b0;
        sec_req_i = 1'b1; sec_addr_i = 32'h300; sec_we_i = 1'b0;
        for (int k = 0; k < 22; k++) begin
            exp_g = (k >= 8) && (((k - 8) % 5) != 4);
            #1;
            vectors++; if (sec_gnt_o !== exp_g) begin miscompares++; $display("FAIL burst_gnt cycle %0d got %b exp %b", k, sec_gnt_o, exp_g); end
            vectors++; if (fetch_enable_o !== !exp_g) begin miscompares++; $display("FAIL burst_fetch_en cycle %0d got %b exp %b", k, fetch_enable_o, !exp_g); end
            vectors++; if (sec_rvalid_o !== exp_prev) begin miscompares++; $display("FAIL burst_rvalid cycle %0d got %b exp %b", k, sec_rvalid_o, exp_prev); end
            exp_prev = exp_g;
            cyc();
        end
        sec_req_i = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_write();
        sec_req_i = 1'b1; sec_we_i = 1'b1; sec_be_i = 4'b0011;
        sec_addr_i = 32'h400; sec_wdata_i = 32'hA5A5A5A5;
        #1;
        vectors++; if (mem_we_o !== 4'b0000) begin miscompares++; $display("FAIL wr_pre_we got %b exp 0000", mem_we_o); end
        cyc();
        stall_i = 1'b1;
        #1;
        vectors++; if (sec_gnt_o !== 1'b1) begin miscompares++; $display("FAIL wr_gnt got %b exp 1", sec_gnt_o); end
        vectors++; if (mem_we_o !== 4'b0011) begin miscompares++; $display("FAIL wr_we got %b exp 0011", mem_we_o); end
        vectors++; if (mem_wdata_o !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL wr_wdata got %h exp a5a5a5a5", mem_wdata_o); end
        vectors++; if (mem_addr_o !== 32'h400) begin miscompares++; $display("FAIL wr_addr got %h exp 00000400", mem_addr_o); end
        cyc();
        sec_req_i = 1'b0; stall_i = 1'b0; sec_we_i = 1'b0;
        #1;
        vectors++; if (sec_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL wr_rvalid got %b exp 0", sec_rvalid_o); end
        vectors++; if (mem_we_o !== 4'b0000) begin miscompares++; $display("FAIL wr_post_we got %b exp 0000", mem_we_o); end
        cyc();
    endtask

    task automatic test_reset_during_grant();
        int n;
        sec_req_i = 1'b1; sec_we_i = 1'b0; stall_i = 1'b1; sec_addr_i = 32'h500;
        #1;
        reset_n = 1'b0;
        #1;
        vectors++; if (sec_gnt_o !== 1'b1) begin miscompares++; $display("FAIL rstg_gnt got %b exp 1", sec_gnt_o); end
        cyc();
        reset_n = 1'b1; sec_req_i = 1'b0; stall_i = 1'b0;
        #1;
        vectors++; if (sec_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL rstg_rvalid got %b exp 0", sec_rvalid_o); end
        cyc();
        sec_req_i = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        sys_reset = 1'b1;
        cyc();
        sys_reset = 1'b0;
        cycles_to_grant(n);
        vectors++; if (n !== 9) begin miscompares++; $display("FAIL sysrst_clears_starve grant at cycle %0d exp 9", n); end
        sys_reset = 1'b1;
        cyc();
        sys_reset = 1'b0; sec_req_i = 1'b0;
        #1;
        vectors++; if (sec_rvalid_o !== 1'b0) begin miscompares++; $display("FAIL sysrst_rvalid got %b exp 0", sec_rvalid_o); end
        cyc();
    endtask

    task automatic test_fetch_only();
        sec_req_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stall_i = ((i % 3) == 1);
            fetch_addr_i = 32'h1000 + 32'(4 * i);
            #1;
            vectors++; if (fetch_enable_o !== !stall_i) begin miscompares++; $display("FAIL fo_fetch_en cycle %0d got %b exp %b", i, fetch_enable_o, !stall_i); end
            vectors++; if (mem_addr_o !== fetch_addr_i) begin miscompares++; $display("FAIL fo_addr cycle %0d got %h exp %h", i, mem_addr_o, fetch_addr_i); end
            vectors++; if (sec_gnt_o !== 1'b0) begin miscompares++; $display("FAIL fo_gnt cycle %0d got %b exp 0", i, sec_gnt_o); end
            cyc();
        end
        stall_i = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; sys_reset = 1'b0; stall_i = 1'b0;
        fetch_addr_i = 32'h40; sec_req_i = 1'b0; sec_addr_i = 32'h0;
        sec_wdata_i = 32'h0; sec_we_i = 1'b0; sec_be_i = 4'h0; mem_rdata_i = 32'h0;
        test_reset();
        test_starve_read();
        test_stall_grant();
        test_burst();
        test_write();
        test_reset_during_grant();
        test_fetch_only();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
